// File: rtl/job_dispatcher_pkg.sv
// Shared definitions for the parent-to-child job dispatcher: FSM encoding,
// command record layout and default sizing.
package job_dispatcher_pkg;

    localparam int DEF_NUM_CORES  = 31;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_ID_W       = 5;
    localparam int ARG_W          = 32;

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_ISSUE      = 2'd1,
        S_BCAST_WAIT = 2'd2
    } state_t;

    // Command record at the default id width, MSB first: {bcast, core, arg1, arg2}
    typedef struct packed {
        logic                bcast;
        logic [DEF_ID_W-1:0] core;
        logic [ARG_W-1:0]    arg1;
        logic [ARG_W-1:0]    arg2;
    } cmd_rec_t;

    // Width of a command record for a given core-id width
    function automatic int cmd_width(input int id_w);
        return 1 + id_w + 2 * ARG_W;
    endfunction

endpackage

// File: rtl/job_dispatcher_cmd_fifo.sv
// Synchronous FIFO with asynchronous active-low reset; read data is the
// current head, valid whenever empty is low.
module cmd_fifo #(
    parameter int WIDTH = 70,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Storage array; payload needs no reset since count gates its visibility
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/job_dispatcher.sv
// Job dispatcher: queues parent commands and delivers them, in order, into
// per-child mailboxes. A busy target blocks the queue head; broadcasts wait
// until every mailbox is free.
module job_dispatcher
    import job_dispatcher_pkg::*;
#(
    parameter int NUM_CORES  = DEF_NUM_CORES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int ID_W       = DEF_ID_W
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [ID_W-1:0]              cmd_core,
    input  logic                         cmd_bcast,
    input  logic [31:0]                  cmd_arg1,
    input  logic [31:0]                  cmd_arg2,
    output logic [NUM_CORES*32-1:0]      job_val_1,
    output logic [NUM_CORES*32-1:0]      job_val_2,
    output logic [NUM_CORES-1:0]         job_flag,
    input  logic [NUM_CORES-1:0]         job_ack,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         idle,
    output logic                         err_bad_id
);

    localparam int CMD_W = cmd_width(ID_W);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    // Same field order as cmd_rec_t, sized by this instance's ID_W
    typedef struct packed {
        logic             bcast;
        logic [ID_W-1:0]  core;
        logic [ARG_W-1:0] arg1;
        logic [ARG_W-1:0] arg2;
    } cmd_t;

    state_t               state;
    state_t               state_nx;
    cmd_t                 push_cmd;
    cmd_t                 head;
    logic [CMD_W-1:0]     head_bits;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 issue_uni;
    logic                 issue_bcast;
    logic                 bad_id;
    logic                 id_ok;
    logic                 target_busy;
    logic                 more_left;
    logic [NUM_CORES-1:0] sel;
    logic [NUM_CORES-1:0] set_mask;

    assign push_cmd  = '{bcast: cmd_bcast, core: cmd_core, arg1: cmd_arg1, arg2: cmd_arg2};
    assign cmd_ready = ~fifo_full;
    assign push      = cmd_valid & cmd_ready;
    assign head      = head_bits;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset),
        .push  (push),
        .wdata (push_cmd),
        .pop   (pop),
        .rdata (head_bits),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Decode the head's target into a one-hot mailbox select (empty for bad ids)
    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sel[i] = ({1'b0, head.core} == (ID_W+1)'(i));
        end
    end

    assign id_ok       = ({1'b0, head.core} < (ID_W+1)'(NUM_CORES));
    assign target_busy = |(sel & job_flag);
    assign more_left   = (fifo_count > CNT_W'(1)) | push;

    // FSM state register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state: arm on any queued or arriving command, park on a blocked broadcast
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                state_nx = (!fifo_empty || push) ? S_ISSUE : S_IDLE;
            end
            S_ISSUE, S_BCAST_WAIT: begin
                if (fifo_empty) begin
                    state_nx = push ? S_ISSUE : S_IDLE;
                end else if (pop) begin
                    state_nx = more_left ? S_ISSUE : S_IDLE;
                end else if (head.bcast) begin
                    state_nx = S_BCAST_WAIT;
                end else begin
                    state_nx = S_ISSUE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // FSM outputs: decide whether the head is delivered, dropped or held this cycle
    always_comb begin
        pop         = 1'b0;
        issue_uni   = 1'b0;
        issue_bcast = 1'b0;
        bad_id      = 1'b0;
        if ((state != S_IDLE) && !fifo_empty) begin
            if (head.bcast) begin
                if (job_flag == '0) begin
                    issue_bcast = 1'b1;
                    pop         = 1'b1;
                end
            end else if (!id_ok) begin
                bad_id = 1'b1;
                pop    = 1'b1;
            end else if (!target_busy) begin
                issue_uni = 1'b1;
                pop       = 1'b1;
            end
        end
    end

    assign set_mask = issue_bcast ? {NUM_CORES{1'b1}} : (issue_uni ? sel : '0);

    // Mailbox flags: issue only targets clear flags, so set and ack never collide
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            job_flag <= '0;
        end else begin
            job_flag <= (job_flag & ~job_ack) | set_mask;
        end
    end

    // Mailbox words change only when a job lands in that mailbox
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            job_val_1 <= '0;
            job_val_2 <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (set_mask[i]) begin
                    job_val_1[32*i +: 32] <= head.arg1;
                    job_val_2[32*i +: 32] <= head.arg2;
                end
            end
        end
    end

    // Sticky record of a dropped out-of-range unicast
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            err_bad_id <= 1'b0;
        end else if (bad_id) begin
            err_bad_id <= 1'b1;
        end
    end

    assign idle = (fifo_count == '0) & ~|job_flag & (state == S_IDLE);

endmodule
